// File: rtl/avr_pkg.sv
// avr_pkg: definitions shared by the AVR program-memory loader and its RAM.
//   ld_state_e - loader FSM states (count low/high byte, data low/high byte, run)
//   NOP        - instruction word shown to the CPU while no image is live
//   AW_DEFAULT - default program-memory word-address width
package avr_pkg;

    typedef enum logic [2:0] {
        CNT_L,
        CNT_H,
        DAT_L,
        DAT_H,
        RUN
    } ld_state_e;

    localparam logic [15:0] NOP        = 16'h0000;
    localparam int          AW_DEFAULT = 9;

endpackage

// File: rtl/avr_pmem_ram.sv
// avr_pmem_ram: 2**AW x 16 single-port program RAM.
//   clk     - clock
//   we      - write enable, data written on the rising edge
//   addr    - shared read/write word address
//   wdata   - write data
//   rdata_q - registered read data (contents of addr before any same-edge write)
// The array has no reset so a loaded image survives a CPU/loader reset.
module avr_pmem_ram
    import avr_pkg::*;
#(
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata_q
);

    logic [15:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

endmodule

// File: rtl/avr_pmem_loader.sv
// avr_pmem_loader: loads a program image from a byte stream into program RAM
// and serves instruction fetches to the CPU once the load is complete.
//   CLK, RST_N - clock, asynchronous active-low reset
//   p_addr     - CPU program-word address (upper bits beyond AW ignored)
//   instr      - instruction word, one-cycle latency, NOP outside RUN
//   cpu_hold   - holds the CPU in reset while an image is being loaded
//   ld_start   - pulse: abandon anything in progress and begin a new load
//   ld_valid, ld_data, ld_ready - byte stream handshake
//   ld_done    - one-cycle pulse on the first cycle of RUN after a load
//   ld_ovf     - sticky: the last image held more words than the RAM depth
// Stream format: word count N (low, high byte), then N words (low, high byte).
module avr_pmem_loader
    import avr_pkg::*;
#(
    parameter int AW = AW_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] p_addr,
    output logic [15:0] instr,
    output logic        cpu_hold,
    input  logic        ld_start,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    output logic        ld_done,
    output logic        ld_ovf
);

    localparam logic [16:0] DEPTH = 17'(1) << AW;

    ld_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] idx_q, idx_d;
    logic [7:0]  lo_q, lo_d;
    logic        ovf_q, ovf_d;
    logic        done_q, done_d;
    logic        rd_ok_q, rd_ok_d;

    logic          xfer;
    logic [16:0]   idx_next;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_wdata;
    logic [15:0]   ram_rdata;
    logic          unused_paddr;

    assign ld_ready     = (state_q != RUN);
    assign cpu_hold     = (state_q != RUN);
    assign ld_done      = done_q;
    assign ld_ovf       = ovf_q;
    assign unused_paddr = ^p_addr[15:AW];

    // ld_start takes priority so a restart never commits a half-received byte.
    assign xfer     = ld_valid && ld_ready && !ld_start;
    assign idx_next = {1'b0, idx_q} + 17'd1;

    // The CPU owns the RAM address in RUN; otherwise the write index does.
    assign ram_addr  = (state_q == RUN) ? p_addr[AW-1:0] : idx_q[AW-1:0];
    assign ram_wdata = {ld_data, lo_q};

    // The RAM output only reflects a CPU address once a full RUN cycle has
    // passed, so the first RUN cycle and every non-RUN cycle show NOP.
    assign instr = (state_q == RUN && rd_ok_q) ? ram_rdata : NOP;

    // Next-state logic: walks count bytes then data bytes, writing each
    // completed word while it still fits and flagging the ones that do not.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lo_d    = lo_q;
        ovf_d   = ovf_q;
        ram_we  = 1'b0;

        if (ld_start) begin
            state_d = CNT_L;
        end else if (xfer) begin
            case (state_q)
                CNT_L: begin
                    cnt_d[7:0] = ld_data;
                    ovf_d      = 1'b0;
                    state_d    = CNT_H;
                end
                CNT_H: begin
                    cnt_d[15:8] = ld_data;
                    if ({ld_data, cnt_q[7:0]} == 16'h0000) begin
                        state_d = RUN;
                    end else begin
                        idx_d   = 16'h0000;
                        state_d = DAT_L;
                    end
                end
                DAT_L: begin
                    lo_d    = ld_data;
                    state_d = DAT_H;
                end
                DAT_H: begin
                    if ({1'b0, idx_q} < DEPTH) begin
                        ram_we = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    idx_d   = idx_next[15:0];
                    state_d = (idx_next < {1'b0, cnt_q}) ? DAT_L : RUN;
                end
                default: begin
                end
            endcase
        end

        done_d  = (state_q != RUN) && (state_d == RUN);
        rd_ok_d = (state_q == RUN);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= CNT_L;
            cnt_q   <= 16'h0000;
            idx_q   <= 16'h0000;
            lo_q    <= 8'h00;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            rd_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            rd_ok_q <= rd_ok_d;
        end
    end

    avr_pmem_ram #(
        .AW (AW)
    ) u_ram (
        .clk     (CLK),
        .we      (ram_we),
        .addr    (ram_addr),
        .wdata   (ram_wdata),
        .rdata_q (ram_rdata)
    );

endmodule

// File: tb/tb_avr_pmem_loader.sv
// tb_avr_pmem_loader: drives two loaders (default AW and AW=2) with the same
// byte streams and compares their outputs against hand-computed values.
module tb_avr_pmem_loader;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [15:0] p_addr;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_data;

    logic [15:0] instr9, instr2;
    logic        hold9, hold2, ready9, ready2, done9, done2, ovf9, ovf2;

    int checks_total  = 0;
    int checks_passed = 0;
    int done_cnt9     = 0;
    int done_cnt2     = 0;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] exp9;
        logic [15:0] exp2;
    } read_vec_t;

    read_vec_t read_tbl [13];

    avr_pmem_loader dut9 (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .p_addr   (p_addr),
        .instr    (instr9),
        .cpu_hold (hold9),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_ready (ready9),
        .ld_done  (done9),
        .ld_ovf   (ovf9)
    );

    avr_pmem_loader #(
        .AW (2)
    ) dut2 (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .p_addr   (p_addr),
        .instr    (instr2),
        .cpu_hold (hold2),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_ready (ready2),
        .ld_done  (done2),
        .ld_ovf   (ovf2)
    );

    always #5 CLK = ~CLK;

    // Count ld_done cycles so a pulse longer than one cycle is caught.
    always @(posedge CLK) begin
        if (done9 === 1'b1) done_cnt9 <= done_cnt9 + 1;
        if (done2 === 1'b1) done_cnt2 <= done_cnt2 + 1;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Presents one byte; with gappy set, inserts 0-3 random idle cycles first.
    task automatic applyStimulus(input logic [7:0] b, input bit gappy);
        int n = 0;
        @(negedge CLK);
        if (gappy) begin
            while (n < 3 && $urandom_range(0, 1) == 0) begin
                ld_valid = 1'b0;
                @(negedge CLK);
                n++;
            end
        end
        ld_valid = 1'b1;
        ld_data  = b;
        checkOutput("ld_ready/cpu_hold during load", {ready9, ready2, hold9, hold2}, 4'b1111);
    endtask

    // Called after the last byte of a load: expects a single ld_done cycle
    // coinciding with cpu_hold falling.
    task automatic finishStream(input string tag);
        int d9 = done_cnt9;
        int d2 = done_cnt2;
        @(negedge CLK);
        ld_valid = 1'b0;
        checkOutput({tag, " ld_done high"}, {done9, done2}, 2'b11);
        checkOutput({tag, " cpu_hold low with done"}, {hold9, hold2}, 2'b00);
        @(negedge CLK);
        checkOutput({tag, " ld_done dropped"}, {done9, done2}, 2'b00);
        checkOutput({tag, " ld_done pulse count"}, {16'(done_cnt9 - d9), 16'(done_cnt2 - d2)},
                    {16'd1, 16'd1});
    endtask

    task automatic startPulse(input string tag);
        @(negedge CLK);
        ld_start = 1'b1;
        @(negedge CLK);
        ld_start = 1'b0;
        checkOutput({tag, " hold after start"}, {hold9, hold2, ready9, ready2}, 4'b1111);
        checkOutput({tag, " instr NOP after start"}, {instr9, instr2}, 32'h0);
    endtask

    task automatic readCheck(input int i);
        @(negedge CLK);
        p_addr = read_tbl[i].addr;
        @(negedge CLK);
        checkOutput($sformatf("instr9 vec%0d", i), {16'h0, instr9}, {16'h0, read_tbl[i].exp9});
        checkOutput($sformatf("instr2 vec%0d", i), {16'h0, instr2}, {16'h0, read_tbl[i].exp2});
    endtask

    task automatic loadImageA(input bit gappy);
        applyStimulus(8'h02, gappy);
        applyStimulus(8'h00, gappy);
        applyStimulus(8'hA1, gappy);
        applyStimulus(8'h50, gappy);
        applyStimulus(8'hA2, gappy);
        applyStimulus(8'h50, gappy);
        finishStream(gappy ? "imageA gappy" : "imageA");
    endtask

    initial begin
        read_tbl[0]  = '{16'h0000, 16'h50A1, 16'h50A1};
        read_tbl[1]  = '{16'h0001, 16'h50A2, 16'h50A2};
        read_tbl[2]  = '{16'h0200, 16'h50A1, 16'h50A1};
        read_tbl[3]  = '{16'hFE01, 16'h50A2, 16'h50A2};
        read_tbl[4]  = '{16'h0000, 16'hB0B1, 16'hB0B1};
        read_tbl[5]  = '{16'h0001, 16'hC0C1, 16'hC0C1};
        read_tbl[6]  = '{16'h0000, 16'h1111, 16'h1111};
        read_tbl[7]  = '{16'h0001, 16'h2222, 16'h2222};
        read_tbl[8]  = '{16'h0002, 16'h3333, 16'h3333};
        read_tbl[9]  = '{16'h0003, 16'h4444, 16'h4444};
        read_tbl[10] = '{16'h0004, 16'h5555, 16'h1111};
        read_tbl[11] = '{16'h0204, 16'h5555, 16'h1111};
        read_tbl[12] = '{16'h0001, 16'h2222, 16'h2222};

        RST_N    = 1'b0;
        p_addr   = 16'h0000;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data  = 8'h00;

        // Reset state
        repeat (2) @(negedge CLK);
        checkOutput("reset cpu_hold", {hold9, hold2}, 2'b11);
        checkOutput("reset instr", {instr9, instr2}, 32'h0);
        checkOutput("reset done/ovf", {done9, done2, ovf9, ovf2}, 4'b0000);
        RST_N = 1'b1;
        @(negedge CLK);
        checkOutput("ready after reset", {ready9, ready2}, 2'b11);

        // Basic two-word load and reads, including address wrap
        $display("[TB] two-word load");
        loadImageA(1'b0);
        for (int i = 0; i < 4; i++) readCheck(i);

        // Restart from RUN and load a different image
        $display("[TB] reload from RUN");
        startPulse("run restart");
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'hB1, 1'b0);
        applyStimulus(8'hB0, 1'b0);
        applyStimulus(8'hC1, 1'b0);
        applyStimulus(8'hC0, 1'b0);
        finishStream("imageB");
        for (int i = 4; i < 6; i++) readCheck(i);

        // Same first image with random idle gaps
        $display("[TB] gappy load");
        startPulse("gappy restart");
        loadImageA(1'b1);
        for (int i = 0; i < 4; i++) readCheck(i);

        // Abort mid-load: start coincides with the high byte, nothing written
        $display("[TB] abort mid-load");
        startPulse("abort restart");
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h11, 1'b0);
        @(negedge CLK);
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 8'h22;
        @(negedge CLK);
        ld_start = 1'b0;
        ld_valid = 1'b0;
        checkOutput("abort hold/done", {hold9, hold2, done9, done2}, 4'b1100);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0);
        finishStream("zero count");
        for (int i = 0; i < 2; i++) readCheck(i);

        // Five words into the AW=2 instance: overflow and wrap
        $display("[TB] overflow load");
        startPulse("ovf restart");
        applyStimulus(8'h05, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h11, 1'b0); applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0); applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h33, 1'b0); applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h44, 1'b0); applyStimulus(8'h44, 1'b0);
        applyStimulus(8'h55, 1'b0); applyStimulus(8'h55, 1'b0);
        finishStream("overflow");
        checkOutput("ld_ovf after overflow", {ovf9, ovf2}, 2'b01);
        for (int i = 6; i < 12; i++) readCheck(i);

        // Overflow flag is sticky until the next count low byte
        startPulse("ovf clear restart");
        checkOutput("ld_ovf sticky after start", {ovf9, ovf2}, 2'b01);
        applyStimulus(8'h00, 1'b0);
        @(negedge CLK);
        ld_valid = 1'b0;
        checkOutput("ld_ovf cleared by count low", {ovf9, ovf2}, 2'b00);
        applyStimulus(8'h00, 1'b0);
        finishStream("ovf clear");

        // Asynchronous reset while running; image survives
        $display("[TB] reset in RUN");
        readCheck(7);
        RST_N = 1'b0;
        #1;
        checkOutput("async reset cpu_hold", {hold9, hold2}, 2'b11);
        checkOutput("async reset instr", {instr9, instr2}, 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0);
        finishStream("post-reset zero count");
        readCheck(12);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
